// File: rtl/mips_instr_encoder.sv
// Loader-side MIPS instruction encoder: encodes symbolic requests, buffers them in a FIFO and
// streams them to consecutive instruction-memory words. ENC_DELAY_SLOT_NOP_EN appends a NOP after BEQ/J.
module mips_instr_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [4:0]    req_rs,
    input  logic [4:0]    req_rt,
    input  logic [4:0]    req_rd,
    input  logic [25:0]   req_imm,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          err,
    output logic          mem_full,
    output logic [AW:0]   word_count,
    output logic          done
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [0:0] ST_ACTIVE = 1'b0;
    localparam logic [0:0] ST_FULL   = 1'b1;

    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
`ifdef ENC_DELAY_SLOT_NOP_EN
    localparam logic [PW:0] NEED_C  = (PW+1)'(2);
`else
    localparam logic [PW:0] NEED_C  = (PW+1)'(1);
`endif

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= 4'd9);
    endfunction

    function automatic logic is_delay_op(input logic [3:0] op);
        return (op == 4'd7) || (op == 4'd9);
    endfunction

    // Opcode/funct map shared with the control-unit decoder
    function automatic logic [31:0] encode(input logic [3:0]  op,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [4:0]  rd,
                                           input logic [25:0] imm);
        logic [31:0] w;
        w = 32'h0000_0000;
        case (op)
            4'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
            4'd1:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
            4'd2:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
            4'd3:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
            4'd4:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
            4'd5:    w = {6'b100011, rs, rt, imm[15:0]};
            4'd6:    w = {6'b101011, rs, rt, imm[15:0]};
            4'd7:    w = {6'b000100, rs, rt, imm[15:0]};
            4'd8:    w = {6'b001000, rs, rt, imm[15:0]};
            4'd9:    w = {6'b000010, imm};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic [0:0]    state_r;
    logic [0:0]    state_nx_s;
    logic [31:0]   mem_r [0:DEPTH-1];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] slot2_s;
    logic [PW:0]   count_r;
    logic [PW:0]   free_s;
    logic [PW:0]   push_n_s;
    logic [AW-1:0] addr_r;
    logic [AW:0]   wcnt_r;
    logic          err_r;
    logic          accept_s;
    logic          push_s;
    logic          nop_s;
    logic          pop_s;
    logic          last_s;
    logic [31:0]   enc_s;

    assign free_s    = DEPTH_C - count_r;
    assign req_ready = !reset && (state_r == ST_ACTIVE) && !clear && (free_s >= NEED_C);
    assign wr_valid  = (state_r == ST_ACTIVE) && (count_r != {(PW+1){1'b0}});
    assign accept_s  = req_valid && req_ready;
    assign push_s    = accept_s && op_legal(req_op);
    assign pop_s     = wr_valid && wr_ready && !clear;
    assign last_s    = (addr_r == {AW{1'b1}});
    assign enc_s     = encode(req_op, req_rs, req_rt, req_rd, req_imm);
    assign slot2_s   = wr_ptr_r + PW'(1);

`ifdef ENC_DELAY_SLOT_NOP_EN
    assign nop_s = push_s && is_delay_op(req_op);
`else
    assign nop_s = 1'b0;
`endif

    // Outputs are driven straight from state registers; the head is masked to zero when empty
    assign wr_data    = (count_r != {(PW+1){1'b0}}) ? mem_r[rd_ptr_r] : 32'h0000_0000;
    assign wr_addr    = addr_r;
    assign word_count = wcnt_r;
    assign err        = err_r;
    assign mem_full   = (state_r == ST_FULL);
    assign done       = (count_r == {(PW+1){1'b0}});

    // Number of words entering the FIFO this edge
    always_comb begin
        push_n_s = {(PW+1){1'b0}};
        if (push_s) begin
            if (nop_s) begin
                push_n_s = (PW+1)'(2);
            end else begin
                push_n_s = (PW+1)'(1);
            end
        end else begin
            push_n_s = {(PW+1){1'b0}};
        end
    end

    // Next-state logic: FULL is entered on the transfer to the last address and left only by clear
    always_comb begin
        state_nx_s = state_r;
        if (clear) begin
            state_nx_s = ST_ACTIVE;
        end else begin
            case (state_r)
                ST_ACTIVE: begin
                    if (pop_s && last_s) begin
                        state_nx_s = ST_FULL;
                    end else begin
                        state_nx_s = ST_ACTIVE;
                    end
                end
                ST_FULL: state_nx_s = ST_FULL;
                default: state_nx_s = ST_ACTIVE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_ACTIVE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FIFO storage; a delay-slot NOP lands in the slot right behind its branch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= enc_s;
            if (nop_s) begin
                mem_r[slot2_s] <= 32'h0000_0000;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else if (clear) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            wr_ptr_r <= wr_ptr_r + push_n_s[PW-1:0];
            count_r  <= count_r + push_n_s - {{PW{1'b0}}, pop_s};
        end
    end

    // Memory address and written-word counter; the address saturates at the last word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r <= {AW{1'b0}};
            wcnt_r <= {(AW+1){1'b0}};
        end else if (clear) begin
            addr_r <= {AW{1'b0}};
            wcnt_r <= {(AW+1){1'b0}};
        end else if (pop_s) begin
            wcnt_r <= wcnt_r + (AW+1)'(1);
            if (!last_s) begin
                addr_r <= addr_r + AW'(1);
            end
        end
    end

    // Illegal-op pulse, one cycle after the accepting edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= accept_s && !op_legal(req_op);
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed scenarios plus random traffic, all compared every cycle
// against a queue-based model of the FIFO, address counter and FULL behaviour.
`timescale 1ns/1ps
module tb_mips_instr_encoder;
    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int CAP   = 1 << AW;
`ifdef ENC_DELAY_SLOT_NOP_EN
    localparam bit NOP_EN = 1'b1;
`else
    localparam bit NOP_EN = 1'b0;
`endif
    localparam int NEED = NOP_EN ? 2 : 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_op = 4'd0;
    logic [4:0]    req_rs = 5'd0;
    logic [4:0]    req_rt = 5'd0;
    logic [4:0]    req_rd = 5'd0;
    logic [25:0]   req_imm = 26'd0;
    logic          wr_valid;
    logic          wr_ready = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          err;
    logic          mem_full;
    logic [AW:0]   word_count;
    logic          done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } xfer_t;

    logic [31:0] q [$];
    xfer_t       log_q [$];
    int          written = 0;
    bit          full_m = 1'b0;
    bit          err_m = 1'b0;

    mips_instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .err(err), .mem_full(mem_full), .word_count(word_count), .done(done)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] ref_word(input logic [3:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [25:0] imm);
        case (op)
            4'd0:    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            4'd1:    return {6'h00, rs, rt, rd, 5'd0, 6'h22};
            4'd2:    return {6'h00, rs, rt, rd, 5'd0, 6'h24};
            4'd3:    return {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4'd4:    return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            4'd5:    return {6'h23, rs, rt, imm[15:0]};
            4'd6:    return {6'h2B, rs, rt, imm[15:0]};
            4'd7:    return {6'h04, rs, rt, imm[15:0]};
            4'd8:    return {6'h08, rs, rt, imm[15:0]};
            4'd9:    return {6'h02, imm};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_ready();
        return !reset && !full_m && !clear && ((DEPTH - q.size()) >= NEED);
    endfunction

    function automatic bit model_valid();
        return !full_m && (q.size() > 0);
    endfunction

    // Reference model: advances on each clock edge from the pre-edge inputs
    always @(posedge clk or posedge reset) begin
        bit rdy;
        bit pop;
        if (reset || clear) begin
            q.delete();
            written = 0;
            full_m  = 1'b0;
            err_m   = 1'b0;
        end else begin
            rdy   = model_ready();
            pop   = model_valid() && wr_ready;
            err_m = rdy && req_valid && (req_op > 4'd9);
            if (pop) begin
                void'(q.pop_front());
                written++;
                if (written == CAP) full_m = 1'b1;
            end
            if (rdy && req_valid && (req_op <= 4'd9)) begin
                q.push_back(ref_word(req_op, req_rs, req_rt, req_rd, req_imm));
                if (NOP_EN && (req_op == 4'd7 || req_op == 4'd9)) q.push_back(32'h0);
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        chk("req_ready", req_ready, model_ready());
        chk("wr_valid", wr_valid, model_valid());
        if (model_valid()) chk("wr_data", wr_data, q[0]);
        chk("wr_addr", wr_addr, (written < CAP) ? written : CAP - 1);
        chk("word_count", word_count, written);
        chk("mem_full", mem_full, full_m);
        chk("err", err, err_m);
        chk("done", done, q.size() == 0);
    end

    // Record the transfers the DUT actually performs
    always @(negedge clk) begin
        if (wr_valid && wr_ready && !clear && !reset) log_q.push_back('{int'(wr_addr), wr_data});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [25:0] imm);
        int n;
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("send_timeout", n < 40, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_w [6];
        int          n;

        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_mem_full", mem_full, 1'b0);
        chk("rst_word_count", word_count, 0);
        chk("rst_done", done, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;

        chk("pin_add", ref_word(4'd0, 5'd1, 5'd2, 5'd3, 26'd0), 32'h00221820);
        chk("pin_lw", ref_word(4'd5, 5'd29, 5'd8, 5'd0, 26'd4), 32'h8FA80004);
        chk("pin_j", ref_word(4'd9, 5'd0, 5'd0, 5'd0, 26'h10), 32'h08000010);

        // ADD: word visible in the cycle after acceptance
        wr_ready = 1'b1;
        send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
        @(negedge clk);
        chk("add_valid", wr_valid, 1'b1);
        chk("add_data", wr_data, 32'h00221820);
        chk("add_addr", wr_addr, 0);
        tick(2);

        // LW, BEQ, J at consecutive addresses
        do_clear();
        log_q.delete();
        send(4'd5, 5'd29, 5'd8, 5'd0, 26'd4);
        send(4'd7, 5'd4, 5'd5, 5'd0, 26'hFFFF);
        send(4'd9, 5'd0, 5'd0, 5'd0, 26'h10);
        tick(8);
        if (NOP_EN) exp_w = '{32'h8FA80004, 32'h1085FFFF, 32'h0, 32'h08000010, 32'h0, 32'h0};
        else        exp_w = '{32'h8FA80004, 32'h1085FFFF, 32'h08000010, 32'h0, 32'h0, 32'h0};
        n = NOP_EN ? 5 : 3;
        chk("seq_len", log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            chk("seq_data", log_q[i].data, exp_w[i]);
            chk("seq_addr", log_q[i].addr, i);
        end

        // Backpressure, then a same-edge push and pop
        do_clear();
        log_q.delete();
        wr_ready = 1'b0;
        n = DEPTH - NEED + 1;
        for (int i = 0; i < n; i++) send(4'd0, 5'd1, 5'd2, 5'(i), 26'd0);
        @(negedge clk);
        chk("bp_ready_low", req_ready, 1'b0);
        tick(1);
        req_op = 4'd0; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd10; req_valid = 1'b1;
        wr_ready = 1'b1;
        tick(1);
        @(negedge clk);
        chk("bp_ready_high", req_ready, 1'b1);
        tick(1);
        req_valid = 1'b0;
        tick(8);
        chk("bp_len", log_q.size(), n + 1);
        for (int i = 0; i < n + 1 && i < log_q.size(); i++)
            chk("bp_order", log_q[i].data, 32'h00220020 | ((i < n ? i : 10) << 11));

        // Illegal op
        do_clear();
        send(4'd12, 5'd3, 5'd3, 5'd3, 26'd7);
        @(negedge clk);
        chk("ill_err", err, 1'b1);
        chk("ill_count", word_count, 0);
        chk("ill_valid", wr_valid, 1'b0);
        @(negedge clk);
        chk("ill_err_pulse", err, 1'b0);
        tick(1);

        // Fill the whole memory, then clear
        do_clear();
        for (int i = 0; i < CAP; i++) send(4'd0, 5'd1, 5'd2, 5'(i), 26'd0);
        tick(3);
        @(negedge clk);
        chk("full_flag", mem_full, 1'b1);
        chk("full_ready", req_ready, 1'b0);
        chk("full_count", word_count, CAP);
        tick(1);
        req_op = 4'd1; req_valid = 1'b1;
        tick(3);
        @(negedge clk);
        chk("full_held", word_count, CAP);
        tick(1);
        req_valid = 1'b0;
        do_clear();
        @(negedge clk);
        chk("clr_addr", wr_addr, 0);
        chk("clr_full", mem_full, 1'b0);
        tick(1);

        // Asynchronous reset with words queued
        send(4'd2, 5'd1, 5'd1, 5'd1, 26'd0);
        tick(2);
        wr_ready = 1'b0;
        send(4'd3, 5'd2, 5'd2, 5'd2, 26'd0);
        send(4'd4, 5'd3, 5'd3, 5'd3, 26'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", wr_valid, 1'b0);
        chk("arst_count", word_count, 0);
        chk("arst_done", done, 1'b1);
        chk("arst_ready", req_ready, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            req_rs    = 5'($urandom);
            req_rt    = 5'($urandom);
            req_rd    = 5'($urandom);
            req_imm   = 26'($urandom);
            wr_ready  = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 49) == 0);
            tick(1);
        end
        clear = 1'b0;
        req_valid = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
